// File: rtl/aes_inv_sbox_pipe.sv
// Pipelined AES inverse S-box on NBYTES byte lanes, inversion done in a GF((2^4)^2) tower field.
// Latency 3 cycles, throughput 1 word/cycle.
// A stall on in_dn_ready freezes each full stage; out_up_ready falls combinationally once the pipe is full.
module aes_inv_sbox_pipe #(
    parameter int NBYTES = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_up_valid,
    input  logic [8*NBYTES-1:0]   in_up_data,
    output logic                  out_up_ready,
    output logic                  out_dn_valid,
    output logic [8*NBYTES-1:0]   out_dn_data,
    input  logic                  in_dn_ready,
    output logic                  out_busy
);

    // GF(2^4) = GF(2)[w]/(w^4+w+1); GF(2^8) = GF(2^4)[Z]/(Z^2+Z+NU) with normal basis {Z^16, Z}.
    // NU = w^3 has trace 1, which makes the quadratic irreducible.
    localparam logic [3:0] NU = 4'h8;

    typedef struct packed {
        logic [3:0] a1;
        logic [3:0] a0;
        logic [3:0] nrm;
    } s1_lane_t;

    typedef struct packed {
        logic [3:0] a1;
        logic [3:0] a0;
        logic [3:0] theta;
    } s2_lane_t;

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // GF(2) matrix stored as 8 packed columns; column k is the image of bit k.
    function automatic logic [7:0] mat_apply(input logic [63:0] cols, input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) r = r ^ cols[8*k +: 8];
        end
        return r;
    endfunction

    // Elaboration-time search for the images of w and Z in the AES field; these fix the basis map.
    function automatic logic [63:0] build_t2p();
        logic [7:0]  w;
        logic [7:0]  z;
        logic [7:0]  x;
        logic [7:0]  wj;
        logic [63:0] cols;
        w    = 8'h00;
        z    = 8'h00;
        cols = '0;
        for (int c = 2; c < 256; c++) begin
            x = 8'(c);
            if (w == 8'h00 && (gf8_mul(gf8_mul(x, x), gf8_mul(x, x)) ^ x ^ 8'h01) == 8'h00)
                w = x;
        end
        for (int c = 2; c < 256; c++) begin
            x = 8'(c);
            if (z == 8'h00 && (gf8_mul(x, x) ^ x ^ gf8_mul(gf8_mul(w, w), w)) == 8'h00)
                z = x;
        end
        wj = 8'h01;
        for (int j = 0; j < 4; j++) begin
            cols[8*j +: 8]     = gf8_mul(wj, z);
            cols[8*(j+4) +: 8] = gf8_mul(wj, z ^ 8'h01);
            wj = gf8_mul(wj, w);
        end
        return cols;
    endfunction

    function automatic logic [63:0] build_p2t(input logic [63:0] fwd);
        logic [63:0] cols;
        cols = '0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 256; c++) begin
                if (mat_apply(fwd, 8'(c)) == 8'(1 << k))
                    cols[8*k +: 8] = 8'(c);
            end
        end
        return cols;
    endfunction

    localparam logic [63:0] T2P = build_t2p();
    localparam logic [63:0] P2T = build_p2t(T2P);

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf4_sq_scl(input logic [3:0] a);
        return gf4_mul(gf4_mul(a, a), NU);
    endfunction

    // a^14 = a^2 * a^4 * a^8; maps 0 to 0 as required.
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] a2;
        logic [3:0] a4;
        logic [3:0] a8;
        a2 = gf4_mul(a, a);
        a4 = gf4_mul(a2, a2);
        a8 = gf4_mul(a4, a4);
        return gf4_mul(gf4_mul(a2, a4), a8);
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // Norm of a1*Z^16 + a0*Z over GF(2^4) is a0*a1 + NU*(a0+a1)^2.
    function automatic s1_lane_t stage1(input logic [7:0] x);
        logic [7:0] t;
        s1_lane_t   r;
        t     = mat_apply(P2T, inv_affine(x));
        r.a1  = t[7:4];
        r.a0  = t[3:0];
        r.nrm = gf4_mul(r.a0, r.a1) ^ gf4_sq_scl(r.a0 ^ r.a1);
        return r;
    endfunction

    function automatic s2_lane_t stage2(input s1_lane_t s);
        s2_lane_t r;
        r.a1    = s.a1;
        r.a0    = s.a0;
        r.theta = gf4_inv(s.nrm);
        return r;
    endfunction

    // Inverse is the conjugate scaled by theta: the Z^16 and Z coefficients swap.
    function automatic logic [7:0] stage3(input s2_lane_t s);
        return mat_apply(T2P, {gf4_mul(s.theta, s.a0), gf4_mul(s.theta, s.a1)});
    endfunction

    logic                   v1;
    logic                   v2;
    logic                   v3;
    logic                   adv1;
    logic                   adv2;
    logic                   adv3;
    s1_lane_t [NBYTES-1:0]  s1_d;
    s1_lane_t [NBYTES-1:0]  s1_q;
    s2_lane_t [NBYTES-1:0]  s2_d;
    s2_lane_t [NBYTES-1:0]  s2_q;
    logic [8*NBYTES-1:0]    s3_d;
    logic [8*NBYTES-1:0]    s3_q;

    assign adv3 = !v3 || in_dn_ready;
    assign adv2 = !v2 || adv3;
    assign adv1 = !v1 || adv2;

    always_comb begin
        s1_d = '0;
        s2_d = '0;
        s3_d = '0;
        for (int i = 0; i < NBYTES; i++) begin
            s1_d[i]         = stage1(in_up_data[8*i +: 8]);
            s2_d[i]         = stage2(s1_q[i]);
            s3_d[8*i +: 8]  = stage3(s2_q[i]);
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_up_valid;
                if (in_up_valid) s1_q <= s1_d;
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) s2_q <= s2_d;
            end
            if (adv3) begin
                v3 <= v2;
                if (v2) s3_q <= s3_d;
            end
        end
    end

    assign out_up_ready = adv1 && !in_rst;
    assign out_dn_valid = v3;
    assign out_dn_data  = s3_q;
    assign out_busy     = v1 || v2 || v3;

endmodule

// File: tb/tb_aes_inv_sbox_pipe.sv
// Bench for aes_inv_sbox_pipe: directed latency/backpressure/reset steps plus a randomized scoreboard run.
module tb_aes_inv_sbox_pipe;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_valid;
    logic [W-1:0] up_data;
    logic         up_ready;
    logic         dn_valid;
    logic [W-1:0] dn_data;
    logic         dn_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   ginv    [256];
    logic [7:0]   inv_tab [256];
    logic [7:0]   fwd_tab [256];
    logic [W-1:0] sb_q    [$];

    aes_inv_sbox_pipe #(.NBYTES(NB)) dut (
        .in_clk      (clk),
        .in_rst      (rst),
        .in_up_valid (up_valid),
        .in_up_data  (up_data),
        .out_up_ready(up_ready),
        .out_dn_valid(dn_valid),
        .out_dn_data (dn_data),
        .in_dn_ready (dn_ready),
        .out_busy    (busy)
    );

    always #5 clk = ~clk;

    // Carry-less product followed by long division by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int prod;
        prod = 0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
        for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (32'h11B << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [W-1:0] map_word(input logic [W-1:0] w, input logic fwd);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < NB; l++)
            r[8*l +: 8] = fwd ? fwd_tab[w[8*l +: 8]] : inv_tab[w[8*l +: 8]];
        return r;
    endfunction

    function automatic logic [W-1:0] sweep_word(input int t);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < NB; l++) r[8*l +: 8] = 8'((t + 64 * l) % 256);
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    initial begin
        logic [W-1:0] bp [4];
        logic [W-1:0] want;
        logic         found;
        int           sent;
        int           got;
        int           cyc;
        logic [7:0]   y;

        // Reference tables straight from field arithmetic: brute-force inverse, then the affine maps.
        for (int x = 0; x < 256; x++) begin
            ginv[x] = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(x), 8'(b)) == 8'h01) ginv[x] = 8'(b);
        end
        for (int x = 0; x < 256; x++) begin
            y = 8'(x);
            inv_tab[x] = ginv[rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05];
            y = ginv[x];
            fwd_tab[x] = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
        end

        rst      = 1'b1;
        up_valid = 1'b0;
        up_data  = '0;
        dn_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rdy_in_reset", W'(up_ready), '0);
        check("rst_dn_valid", W'(dn_valid), '0);
        check("rst_dn_data", dn_data, '0);
        check("rst_busy", W'(busy), '0);

        // Known vector, presented in the very first cycle out of reset.
        rst      = 1'b0;
        up_valid = 1'b1;
        up_data  = 32'h637C00FF;
        #1;
        check("rdy_first_cycle", W'(up_ready), W'(1));
        @(posedge clk); #1;
        up_valid = 1'b0;
        check("kv_busy", W'(busy), W'(1));
        check("kv_vld_c1", W'(dn_valid), '0);
        @(posedge clk); #1;
        check("kv_vld_c2", W'(dn_valid), '0);
        @(posedge clk); #1;
        check("kv_vld_c3", W'(dn_valid), W'(1));
        check("kv_dat", dn_data, 32'h0001527D);
        @(posedge clk); #1;
        check("kv_vld_c4", W'(dn_valid), '0);
        check("kv_idle", W'(busy), '0);

        // Every byte value in every lane, back-to-back.
        for (int t = 0; t < 259; t++) begin
            up_valid = (t < 256);
            up_data  = (t < 256) ? sweep_word(t) : '0;
            @(negedge clk);
            if (t < 256) check("sweep_rdy", W'(up_ready), W'(1));
            check("sweep_vld", W'(dn_valid), W'(t >= 3));
            if (t >= 3) check("sweep_dat", dn_data, map_word(sweep_word(t - 3), 1'b0));
            @(posedge clk); #1;
        end
        up_valid = 1'b0;

        // Backpressure: three words fill the pipe, the fourth waits.
        for (int c = 0; c < 4; c++) bp[c] = W'($urandom);
        dn_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            up_valid = 1'b1;
            up_data  = bp[c];
            @(negedge clk);
            check("bp_rdy", W'(up_ready), W'(c < 3));
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_vld", W'(dn_valid), W'(1));
            check("bp_hold_dat", dn_data, map_word(bp[0], 1'b0));
            check("bp_hold_rdy", W'(up_ready), '0);
            @(posedge clk); #1;
        end
        dn_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_rel_vld", W'(dn_valid), W'(1));
            check("bp_rel_dat", dn_data, map_word(bp[k], 1'b0));
            if (k == 0) check("bp_rel_rdy", W'(up_ready), W'(1));
            @(posedge clk); #1;
            up_valid = 1'b0;
        end
        @(negedge clk);
        check("bp_drained", W'(dn_valid), '0);
        @(posedge clk); #1;

        // Reset with three words in flight.
        dn_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            up_valid = 1'b1;
            up_data  = W'($urandom);
            @(posedge clk); #1;
        end
        up_valid = 1'b0;
        check("mid_busy", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        check("mid_rdy_in_reset", W'(up_ready), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_vld", W'(dn_valid), '0);
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_dat", dn_data, '0);
        dn_ready = 1'b1;
        up_valid = 1'b1;
        up_data  = {NB{8'h52}};
        #1;
        check("mid_rdy_after", W'(up_ready), W'(1));
        @(posedge clk); #1;
        up_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (dn_valid) begin
                found = 1'b1;
                check("mid_new_word", dn_data, {NB{8'h48}});
            end
            @(posedge clk); #1;
        end
        check("mid_new_seen", W'(found), W'(1));
        @(negedge clk);
        check("mid_no_stale", W'(dn_valid), '0);
        @(posedge clk); #1;

        // Random valid/ready against a queue scoreboard, with a forward S-box round trip.
        sent = 0;
        got  = 0;
        cyc  = 0;
        sb_q.delete();
        while ((sent < 10000 || sb_q.size() != 0) && cyc < 80000) begin
            up_valid = (sent < 10000) && ($urandom_range(0, 99) < 70);
            up_data  = W'($urandom);
            dn_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            if (dn_valid && dn_ready) begin
                if (sb_q.size() == 0) begin
                    check("rnd_extra", W'(dn_valid), '0);
                end else begin
                    want = sb_q.pop_front();
                    check("rnd_dat", dn_data, map_word(want, 1'b0));
                    check("rnd_roundtrip", map_word(dn_data, 1'b1), want);
                    got++;
                end
            end
            if (up_valid && up_ready) begin
                sb_q.push_back(up_data);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        up_valid = 1'b0;
        dn_ready = 1'b1;
        check("rnd_words_out", W'(got), W'(10000));
        #1;
        check("rnd_idle", W'(busy), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
